// File: rtl/dpll_ctrl_pkg.sv
// Shared state, gain encodings and DCO width for the DPLL lock sequencer.
package dpll_ctrl_pkg;

  localparam int unsigned DCO_CODE_W = 13;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RESET_HOLD = 3'd1,
    ACQUIRE    = 3'd2,
    TRACK      = 3'd3,
    FAIL       = 3'd4
  } seq_state_t;

  typedef logic [1:0] gain_sel_t;

  localparam gain_sel_t GAIN_HOLD   = 2'd0;
  localparam gain_sel_t GAIN_WIDE   = 2'd1;
  localparam gain_sel_t GAIN_NARROW = 2'd2;

endpackage

// File: rtl/dpll_lock_sequencer_if.sv
// Control/status bundle between the lock sequencer and the DPLL datapath.
interface dpll_lock_sequencer_if
  import dpll_ctrl_pkg::*;
#(
  parameter int unsigned ERR_W  = 8,
  parameter int unsigned CODE_W = DCO_CODE_W
) ();

  logic                     enable;
  logic                     err_valid;
  logic signed [ERR_W-1:0]  phase_err;
  logic                     dpll_reset;
  logic        [CODE_W-1:0] dco_init;
  gain_sel_t                gain_sel;
  logic                     locked;
  logic                     fail;
  logic        [2:0]        state;

  modport master (
    input  enable, err_valid, phase_err,
    output dpll_reset, dco_init, gain_sel, locked, fail, state
  );

  modport slave (
    output enable, err_valid, phase_err,
    input  dpll_reset, dco_init, gain_sel, locked, fail, state
  );

endinterface

// File: rtl/dpll_lock_sequencer_phase_err_qual.sv
// Saturating |phase_err| with run-length counters for in-tolerance and
// out-of-tolerance samples; hits fire on the sample that completes a run.
module dpll_lock_sequencer_phase_err_qual #(
  parameter int unsigned ERR_W      = 8,
  parameter int unsigned LOCK_TOL   = 2,
  parameter int unsigned LOCK_CNT   = 32,
  parameter int unsigned UNLOCK_TOL = 6,
  parameter int unsigned UNLOCK_CNT = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr,
  input  logic                    err_valid,
  input  logic signed [ERR_W-1:0] phase_err,
  output logic                    lock_hit_c,
  output logic                    unlock_hit_c
);

  localparam int unsigned LC_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned UC_W = $clog2(UNLOCK_CNT + 1);
  localparam logic [ERR_W-1:0] ERR_MIN = {1'b1, {(ERR_W-1){1'b0}}};
  localparam logic [ERR_W-1:0] ERR_MAX = {1'b0, {(ERR_W-1){1'b1}}};

  logic [ERR_W-1:0] err_raw;
  logic [ERR_W-1:0] err_abs;
  logic             in_tol_c;
  logic             out_tol_c;
  logic [LC_W-1:0]  lock_cnt_q;
  logic [UC_W-1:0]  unl_cnt_q;

  assign err_raw = phase_err;

  // Most-negative code has no positive twin; clamp it to the largest magnitude.
  always_comb begin
    err_abs = err_raw;
    if (err_raw == ERR_MIN)      err_abs = ERR_MAX;
    else if (err_raw[ERR_W-1])   err_abs = ERR_W'(-err_raw);
  end

  assign in_tol_c  = err_abs <= ERR_W'(LOCK_TOL);
  assign out_tol_c = err_abs >  ERR_W'(UNLOCK_TOL);

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      lock_cnt_q <= '0;
      unl_cnt_q  <= '0;
    end else if (err_valid) begin
      if (!in_tol_c)                             lock_cnt_q <= '0;
      else if (lock_cnt_q != LC_W'(LOCK_CNT))    lock_cnt_q <= lock_cnt_q + LC_W'(1);
      if (!out_tol_c)                            unl_cnt_q  <= '0;
      else if (unl_cnt_q != UC_W'(UNLOCK_CNT))   unl_cnt_q  <= unl_cnt_q + UC_W'(1);
    end
  end

  assign lock_hit_c   = err_valid && in_tol_c  && (lock_cnt_q >= LC_W'(LOCK_CNT - 1));
  assign unlock_hit_c = err_valid && out_tol_c && (unl_cnt_q  >= UC_W'(UNLOCK_CNT - 1));

endmodule

// File: rtl/dpll_lock_sequencer.sv
// DPLL bring-up and lock supervisor: reset hold, wide acquisition, narrow
// tracking, loss-of-lock re-acquisition and sticky failure after retries.
module dpll_lock_sequencer
  import dpll_ctrl_pkg::*;
#(
  parameter int unsigned       ERR_W      = 8,
  parameter int unsigned       CODE_W     = DCO_CODE_W,
  parameter logic [CODE_W-1:0] INIT_CODE  = CODE_W'(13'h1000),
  parameter int unsigned       RST_CYCLES = 8,
  parameter int unsigned       LOCK_TOL   = 2,
  parameter int unsigned       LOCK_CNT   = 32,
  parameter int unsigned       UNLOCK_TOL = 6,
  parameter int unsigned       UNLOCK_CNT = 4,
  parameter int unsigned       ACQ_TMO    = 4096,
  parameter int unsigned       MAX_RETRY  = 3
) (
  input logic                   clk_ref,
  input logic                   reset_n,
  dpll_lock_sequencer_if.master bus
);

  localparam int unsigned TMR_W   = $clog2(((ACQ_TMO > RST_CYCLES) ? ACQ_TMO : RST_CYCLES) + 1);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

  seq_state_t         state_q, state_d;
  logic [TMR_W-1:0]   tmr_q;
  logic [RETRY_W-1:0] retry_q;
  logic               lock_hit_c, unlock_hit_c, tmo_hit_c, retry_last_c;
  logic               dpll_reset_d, locked_d, fail_d;
  gain_sel_t          gain_d;
  logic               dpll_reset_q, locked_q, fail_q;
  gain_sel_t          gain_q;
  logic [CODE_W-1:0]  dco_init_q;

  assign tmo_hit_c    = tmr_q == TMR_W'(ACQ_TMO - 1);
  assign retry_last_c = retry_q >= RETRY_W'(MAX_RETRY - 1);

  // Run-length counters restart on every state change.
  dpll_lock_sequencer_phase_err_qual #(
    .ERR_W(ERR_W), .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT),
    .UNLOCK_TOL(UNLOCK_TOL), .UNLOCK_CNT(UNLOCK_CNT)
  ) u_qual (
    .clk          (clk_ref),
    .reset_n      (reset_n),
    .clr          (state_d != state_q),
    .err_valid    (bus.err_valid),
    .phase_err    (bus.phase_err),
    .lock_hit_c   (lock_hit_c),
    .unlock_hit_c (unlock_hit_c)
  );

  always_ff @(posedge clk_ref) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Lock beats timeout; enable low overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (bus.enable) state_d = RESET_HOLD;
      RESET_HOLD: if (tmr_q == TMR_W'(RST_CYCLES - 1)) state_d = ACQUIRE;
      ACQUIRE: begin
        if (lock_hit_c)     state_d = TRACK;
        else if (tmo_hit_c) state_d = retry_last_c ? FAIL : RESET_HOLD;
      end
      TRACK:      if (unlock_hit_c) state_d = ACQUIRE;
      FAIL:       state_d = FAIL;
      default:    state_d = IDLE;
    endcase
    if (!bus.enable) state_d = IDLE;
  end

  always_comb begin
    dpll_reset_d = 1'b1;
    gain_d       = GAIN_HOLD;
    locked_d     = 1'b0;
    fail_d       = 1'b0;
    case (state_d)
      ACQUIRE: begin
        dpll_reset_d = 1'b0;
        gain_d       = GAIN_WIDE;
      end
      TRACK: begin
        dpll_reset_d = 1'b0;
        gain_d       = GAIN_NARROW;
        locked_d     = 1'b1;
      end
      FAIL:    fail_d = 1'b1;
      default: ;
    endcase
  end

  // Shared hold/timeout timer and acquisition retry count.
  always_ff @(posedge clk_ref) begin
    if (!reset_n) begin
      tmr_q   <= '0;
      retry_q <= '0;
    end else begin
      if (state_d != state_q)  tmr_q <= '0;
      else if (tmr_q != '1)    tmr_q <= tmr_q + TMR_W'(1);
      if (state_d == IDLE || state_d == TRACK)
        retry_q <= '0;
      else if (state_q == ACQUIRE && state_d != ACQUIRE && retry_q != '1)
        retry_q <= retry_q + RETRY_W'(1);
    end
  end

  always_ff @(posedge clk_ref) begin
    if (!reset_n) begin
      dpll_reset_q <= 1'b1;
      dco_init_q   <= INIT_CODE;
      gain_q       <= GAIN_HOLD;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      dpll_reset_q <= dpll_reset_d;
      dco_init_q   <= INIT_CODE;
      gain_q       <= gain_d;
      locked_q     <= locked_d;
      fail_q       <= fail_d;
    end
  end

  assign bus.dpll_reset = dpll_reset_q;
  assign bus.dco_init   = dco_init_q;
  assign bus.gain_sel   = gain_q;
  assign bus.locked     = locked_q;
  assign bus.fail       = fail_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_dpll_lock_sequencer.sv
// Scoreboard bench for dpll_lock_sequencer: a cycle-level reference model
// predicts every registered output; a monitor compares after each edge.
module tb_dpll_lock_sequencer;

  localparam int unsigned ERR_W      = 8;
  localparam int unsigned CODE_W     = 13;
  localparam int unsigned RST_CYCLES = 8;
  localparam int unsigned LOCK_TOL   = 2;
  localparam int unsigned LOCK_CNT   = 32;
  localparam int unsigned UNLOCK_TOL = 6;
  localparam int unsigned UNLOCK_CNT = 4;
  localparam int unsigned ACQ_TMO    = 4096;
  localparam int unsigned MAX_RETRY  = 3;
  localparam logic [CODE_W-1:0] INIT_CODE = 13'h1000;

  typedef struct packed {
    logic              dpll_reset;
    logic [CODE_W-1:0] dco_init;
    logic [1:0]        gain_sel;
    logic              locked;
    logic              fail;
    logic [2:0]        state;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n;

  dpll_lock_sequencer_if #(.ERR_W(ERR_W), .CODE_W(CODE_W)) bus ();

  dpll_lock_sequencer #(
    .ERR_W(ERR_W), .CODE_W(CODE_W), .INIT_CODE(INIT_CODE), .RST_CYCLES(RST_CYCLES),
    .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT), .UNLOCK_TOL(UNLOCK_TOL),
    .UNLOCK_CNT(UNLOCK_CNT), .ACQ_TMO(ACQ_TMO), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk_ref (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: mode numbers follow the debug state encoding.
  int m_mode = 0, m_time = 0, m_good = 0, m_bad = 0, m_tries = 0;

  task automatic model_step(input bit rn, input bit en, input bit v, input int err);
    int a;
    int nxt;
    a = (err < 0) ? -err : err;
    if (a > 127) a = 127;
    nxt = m_mode;
    if (!rn || !en) nxt = 0;
    else begin
      case (m_mode)
        0: nxt = 1;
        1: begin
          m_time++;
          if (m_time == int'(RST_CYCLES)) nxt = 2;
        end
        2: begin
          m_time++;
          if (v) m_good = (a <= int'(LOCK_TOL)) ? m_good + 1 : 0;
          if (m_good == int'(LOCK_CNT)) begin
            nxt = 3;
            m_tries = 0;
          end else if (m_time == int'(ACQ_TMO)) begin
            m_tries++;
            nxt = (m_tries == int'(MAX_RETRY)) ? 4 : 1;
          end
        end
        3: begin
          if (v) m_bad = (a > int'(UNLOCK_TOL)) ? m_bad + 1 : 0;
          if (m_bad == int'(UNLOCK_CNT)) nxt = 2;
        end
        default: ;
      endcase
    end
    if (nxt == 0) m_tries = 0;
    if (nxt != m_mode || !rn) begin
      m_time = 0;
      m_good = 0;
      m_bad  = 0;
    end
    m_mode = nxt;
  endtask

  function automatic obs_t expect_of(input int mode);
    obs_t o;
    o.dpll_reset = (mode == 0) || (mode == 1) || (mode == 4);
    o.dco_init   = INIT_CODE;
    o.gain_sel   = (mode == 2) ? 2'd1 : (mode == 3) ? 2'd2 : 2'd0;
    o.locked     = (mode == 3);
    o.fail       = (mode == 4);
    o.state      = 3'(mode);
    return o;
  endfunction

  task automatic step(input bit rn, input bit en, input bit v, input int err);
    @(negedge clk);
    reset_n       = rn;
    bus.enable    = en;
    bus.err_valid = v;
    bus.phase_err = ERR_W'(err);
    model_step(rn, en, v, err);
    exp_q.push_back(expect_of(m_mode));
  endtask

  task automatic run(input int n, input bit rn, input bit en, input bit v, input int err);
    for (int i = 0; i < n; i++) step(rn, en, v, err);
  endtask

  // Monitor: one expected vector per clock edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        obs_t e;
        obs_t g;
        e = exp_q.pop_front();
        g = {bus.dpll_reset, bus.dco_init, bus.gain_sel, bus.locked, bus.fail, bus.state};
        n_vec++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL vec%0d t=%0t: got rst=%0b dco=%h gain=%0d lock=%0b fail=%0b st=%0d, need rst=%0b dco=%h gain=%0d lock=%0b fail=%0b st=%0d",
                   n_vec, $time, g.dpll_reset, g.dco_init, g.gain_sel, g.locked, g.fail, g.state,
                   e.dpll_reset, e.dco_init, e.gain_sel, e.locked, e.fail, e.state);
        end
      end
    end
  end

  initial begin
    reset_n       = 1'b0;
    bus.enable    = 1'b0;
    bus.err_valid = 1'b0;
    bus.phase_err = '0;

    run(3, 0, 0, 0, 0);
    // Clean bring-up: reset drops at edge 9, lock at edge 41.
    run(45, 1, 1, 1, 0);
    // Phase step: unlock on 4th bad sample, then relock.
    run(4, 1, 1, 1, 20);
    run(34, 1, 1, 1, 0);
    // Three-sample glitch must not unlock.
    run(3, 1, 1, 1, 20);
    run(10, 1, 1, 1, 0);
    // Tracking noise inside unlock tolerance, with valid gaps.
    for (int i = 0; i < 200; i++)
      step(1, 1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 12)) - 6);
    // Reset while tracking.
    step(0, 1, 1, 0);
    run(2, 1, 0, 0, 0);
    // Most-negative error is out of tolerance; valid gaps keep the lock run.
    run(30, 1, 1, 1, -128);
    for (int i = 0; i < 120; i++)
      step(1, 1, 1'($urandom_range(0, 2) != 0), 0);
    // Enable drop mid-acquisition.
    run(1, 1, 0, 0, 0);
    run(20, 1, 1, 1, 0);
    run(1, 1, 0, 1, 0);
    // Lock completes on the same edge the timeout expires.
    run(int'(RST_CYCLES + 1 + ACQ_TMO - LOCK_CNT), 1, 1, 1, 5);
    run(int'(LOCK_CNT) + 5, 1, 1, 1, 0);
    // Constant error between tolerances: three timeouts then sticky failure.
    run(1, 1, 0, 0, 0);
    run(int'(MAX_RETRY * (RST_CYCLES + ACQ_TMO)) + 20, 1, 1, 1, 5);
    run(3, 1, 0, 1, 5);
    // Random soak.
    for (int i = 0; i < 3000; i++) begin
      int r;
      int e;
      r = int'($urandom_range(0, 99));
      if (r < 75)      e = int'($urandom_range(0, 4)) - 2;
      else if (r < 92) e = int'($urandom_range(0, 20)) - 10;
      else             e = int'($urandom_range(0, 255)) - 128;
      step(1'($urandom_range(0, 599) != 0), 1'($urandom_range(0, 299) != 0),
           1'($urandom_range(0, 3) != 0), e);
    end

    @(posedge clk);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors never compared, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
